// File: rtl/lfsr_rand_gen_mc.sv
// Multi-channel Galois-LFSR payload generator with a registered
// valid/ready output stream and per-channel reseeding.
module lfsr_rand_gen_mc #(
    parameter int              RW           = 32,
    parameter int              NCH          = 4,
    parameter int              OB           = 1,
    parameter int              STEPS        = 1,
    parameter logic [RW-1:0]   POLY         = {(RW/8){8'hA3}},
    parameter logic [RW-1:0]   DEFAULT_SEED = {{(RW-1){1'b0}}, 1'b1},
    parameter int              CW           = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic [NCH-1:0]      i_load_mask,
    input  logic [RW-1:0]       i_seed,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [NCH*OB*8-1:0] o_data,
    output logic [CW-1:0]       o_count
);

    localparam int DW = 8 * OB;

    logic [RW-1:0]       state_q [NCH];
    logic [RW-1:0]       state_d [NCH];
    logic [NCH*DW-1:0]   data_q;
    logic [NCH*DW-1:0]   data_d;
    logic                valid_q;
    logic                valid_d;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic [RW-1:0]       seed_eff;
    logic                fire;
    logic                gen;

    function automatic logic [RW-1:0] step1(input logic [RW-1:0] s);
        logic [RW-1:0] taps;
        taps = {POLY[RW-1:1], 1'b0} & {RW{s[RW-1]}};
        return {s[RW-2:0], s[RW-1]} ^ taps;
    endfunction

    function automatic logic [RW-1:0] advance(input logic [RW-1:0] s);
        logic [RW-1:0] t;
        t = s;
        for (int k = 0; k < STEPS; k++) begin
            t = step1(t);
        end
        return t;
    endfunction

    // A zero seed would lock the LFSR, so it maps to the default.
    assign seed_eff = (i_seed == '0) ? DEFAULT_SEED : i_seed;
    assign fire     = valid_q & i_ready;
    assign gen      = i_en & (~valid_q | fire);

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        for (int c = 0; c < NCH; c++) begin
            state_d[c] = state_q[c];
        end
        if (gen) begin
            valid_d = 1'b1;
            for (int c = 0; c < NCH; c++) begin
                data_d[c*DW +: DW] = state_q[c][DW-1:0];
                state_d[c]         = advance(state_q[c]);
            end
        end else if (fire) begin
            valid_d = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (i_load_mask[c]) begin
                state_d[c] = seed_eff;
            end
        end
        if (fire) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= DEFAULT_SEED;
            end
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= state_d[c];
            end
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_lfsr_rand_gen_mc.sv
// Directed-vector bench for lfsr_rand_gen_mc: default build plus a
// STEPS=8 / CW=4 build checked against a bit-level reference model.
module tb_lfsr_rand_gen_mc;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, rdy, vld;
    logic [3:0]  ld;
    logic [31:0] seed, dat;
    logic [15:0] cnt;

    logic        rst2, en2, rdy2, vld2;
    logic [3:0]  ld2;
    logic [31:0] seed2, dat2;
    logic [3:0]  cnt2;

    int n_chk = 0;
    int n_err = 0;

    lfsr_rand_gen_mc dut (
        .clk(clk), .rst(rst), .i_en(en), .i_load_mask(ld),
        .i_seed(seed), .o_valid(vld), .i_ready(rdy),
        .o_data(dat), .o_count(cnt)
    );

    lfsr_rand_gen_mc #(.STEPS(8), .CW(4)) dut2 (
        .clk(clk), .rst(rst2), .i_en(en2), .i_load_mask(ld2),
        .i_seed(seed2), .o_valid(vld2), .i_ready(rdy2),
        .o_data(dat2), .o_count(cnt2)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        rdy;
        logic [3:0]  ld;
        logic [31:0] seed;
        logic        ev;
        logic [31:0] ed;
        logic [15:0] ec;
    } vec_t;

    vec_t vt[24];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference step written straight from the bit equation.
    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] n;
        logic [31:0] poly;
        poly = 32'hA3A3A3A3;
        n[0] = s[31];
        for (int i = 1; i < 32; i++) begin
            n[i] = poly[i] ? (s[i-1] ^ s[31]) : s[i-1];
        end
        return n;
    endfunction

    initial begin
        logic [31:0] m;
        rst = 1'b1; en = 1'b0; rdy = 1'b0; ld = 4'h0; seed = 32'h0;
        rst2 = 1'b1; en2 = 1'b0; rdy2 = 1'b0; ld2 = 4'h0; seed2 = 32'h0;

        //            rst   en    rdy   ld     seed          ev    ed            ec
        vt[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h00000000, 16'd0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 4'h1, 32'h80000000, 1'b0, 32'h00000000, 16'd0};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,        1'b1, 32'h01010100, 16'd0};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,        1'b1, 32'h020202A3, 16'd1};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,        1'b1, 32'h040404E5, 16'd2};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h040404E5, 16'd2};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h040404E5, 16'd2};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h040404E5, 16'd2};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h040404E5, 16'd2};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h040404E5, 16'd2};
        vt[10] = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,        1'b1, 32'h08080869, 16'd3};
        vt[11] = '{1'b0, 1'b0, 1'b1, 4'h0, 32'h0,        1'b0, 32'h08080869, 16'd4};
        vt[12] = '{1'b0, 1'b0, 1'b1, 4'h0, 32'h0,        1'b0, 32'h08080869, 16'd4};
        vt[13] = '{1'b0, 1'b0, 1'b0, 4'hF, 32'h0,        1'b0, 32'h08080869, 16'd4};
        vt[14] = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,        1'b1, 32'h01010101, 16'd4};
        vt[15] = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,        1'b1, 32'h02020202, 16'd5};
        vt[16] = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,        1'b1, 32'h04040404, 16'd6};
        vt[17] = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,        1'b1, 32'h08080808, 16'd7};
        vt[18] = '{1'b0, 1'b1, 1'b1, 4'h4, 32'h12345678, 1'b1, 32'h10101010, 16'd8};
        vt[19] = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,        1'b1, 32'h20782020, 16'd9};
        vt[20] = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,        1'b1, 32'h40F04040, 16'd10};
        vt[21] = '{1'b1, 1'b1, 1'b1, 4'h0, 32'h0,        1'b0, 32'h00000000, 16'd0};
        vt[22] = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,        1'b1, 32'h01010101, 16'd0};
        vt[23] = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,        1'b1, 32'h02020202, 16'd1};

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rst = vt[i].rst; en = vt[i].en; rdy = vt[i].rdy;
            ld = vt[i].ld; seed = vt[i].seed;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), {31'h0, vld}, {31'h0, vt[i].ev});
            chk($sformatf("v%0d data", i), dat, vt[i].ed);
            chk($sformatf("v%0d count", i), {16'h0, cnt}, {16'h0, vt[i].ec});
        end
        @(negedge clk);
        en = 1'b0; rdy = 1'b0; ld = 4'h0;

        // STEPS=8 build: reset, explicit seed of 1, then free-run.
        rst2 = 1'b1;
        @(posedge clk); #1;
        chk("s8 rst valid", {31'h0, vld2}, 32'h0);
        chk("s8 rst count", {28'h0, cnt2}, 32'h0);
        @(negedge clk);
        rst2 = 1'b0; ld2 = 4'hF; seed2 = 32'h00000001;
        @(negedge clk);
        ld2 = 4'h0; en2 = 1'b1; rdy2 = 1'b1;
        m = 32'h00000001;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            chk($sformatf("s8 w%0d data", i), dat2, {4{m[7:0]}});
            chk($sformatf("s8 w%0d valid", i), {31'h0, vld2}, 32'h1);
            chk($sformatf("s8 w%0d count", i), {28'h0, cnt2},
                32'(i % 16));
            if (i == 0) chk("s8 byte0", {24'h0, dat2[7:0]}, 32'h01);
            if (i == 1) chk("s8 byte1", {24'h0, dat2[7:0]}, 32'h00);
            if (i == 3) chk("s8 byte3", {24'h0, dat2[7:0]}, 32'h00);
            if (i == 17) chk("s8 cnt wrap", {28'h0, cnt2}, 32'h1);
            for (int k = 0; k < 8; k++) m = ref_step(m);
        end
        @(negedge clk);
        en2 = 1'b0; rdy2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
